// File: rtl/am_pkg.sv
// Shared constants, types and FSM encoding for the associative-memory similarity stage.
package am_pkg;

    localparam int NUM_CLASSES = 26;
    localparam int HV_DIM      = 5120;
    localparam int CHUNK_W     = 64;
    localparam int SIM_W       = 13;

    localparam int NUM_CHUNKS  = HV_DIM / CHUNK_W;
    localparam int ADDR_W      = $clog2(NUM_CHUNKS);
    localparam int POP_W       = $clog2(CHUNK_W + 1);

    typedef logic [SIM_W-1:0] sim_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } am_acc_state_t;

endpackage

// File: rtl/am_popcount.sv
// Combinational popcount of a W-bit vector, built as a balanced binary adder tree.
module am_popcount #(
    parameter int W     = 64,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     bits,
    output logic [CNT_W-1:0] count
);

    localparam int LEVELS = (W > 1) ? $clog2(W) : 0;
    localparam int LEAVES = 1 << LEVELS;

    // Heap-ordered tree: node i sums nodes 2i and 2i+1, leaves sit at LEAVES..2*LEAVES-1.
    function automatic logic [CNT_W-1:0] tree_count(input logic [W-1:0] b);
        logic [CNT_W-1:0] node [1:2*LEAVES-1];
        for (int i = 0; i < LEAVES; i++) begin
            if (i < W) node[LEAVES+i] = CNT_W'(b[i]);
            else       node[LEAVES+i] = '0;
        end
        for (int i = LEAVES - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i+1];
        end
        return node[1];
    endfunction

    assign count = tree_count(bits);

endmodule

// File: rtl/am_similarity_accumulator.sv
// Streams query chunks against all class HVs read from the AM SRAM and accumulates
// per-class popcount(query & class) similarities, pulsing inferring_class when final.
module am_similarity_accumulator
    import am_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  nrst,
    input  logic                                  start,
    input  logic                                  query_valid,
    output logic                                  query_ready,
    input  logic [CHUNK_W-1:0]                    query_chunk,
    output logic                                  am_rd_en,
    output logic [ADDR_W-1:0]                     am_rd_addr,
    input  logic [NUM_CLASSES-1:0][CHUNK_W-1:0]   am_rd_data,
    output sim_t                                  similarity_values [0:NUM_CLASSES-1],
    output logic                                  inferring_class,
    output logic                                  busy
);

    if (HV_DIM > 2**SIM_W - 1) begin : g_sim_w_too_narrow
        $error("SIM_W too narrow to hold a full-HV similarity");
    end
    if (HV_DIM % CHUNK_W != 0) begin : g_dim_not_chunk_multiple
        $error("HV_DIM must be a multiple of CHUNK_W");
    end

    am_acc_state_t      state_q, state_d;
    logic [ADDR_W-1:0]  chunk_cnt_q, chunk_cnt_d;
    logic [CHUNK_W-1:0] query_q, query_d;
    logic               add_pend_q, add_pend_d;
    logic               infer_q, infer_d;
    sim_t               acc_q [NUM_CLASSES];
    sim_t               acc_d [NUM_CLASSES];
    logic [POP_W-1:0]   pop [NUM_CLASSES];
    logic               handshake;

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_pop
        am_popcount #(.W(CHUNK_W), .CNT_W(POP_W)) u_popcount (
            .bits  (query_q & am_rd_data[k]),
            .count (pop[k])
        );
    end

    assign handshake = (state_q == ACCUM) && query_valid;

    always_comb begin
        // NOTE: every _d gets a hold value up front so no path through the case infers a latch.
        state_d     = state_q;
        chunk_cnt_d = chunk_cnt_q;
        query_d     = query_q;
        add_pend_d  = 1'b0;
        infer_d     = 1'b0;
        for (int k = 0; k < NUM_CLASSES; k++) acc_d[k] = acc_q[k];

        // SRAM data for the chunk read last cycle is on am_rd_data now.
        if (add_pend_q) begin
            for (int k = 0; k < NUM_CLASSES; k++) acc_d[k] = acc_q[k] + SIM_W'(pop[k]);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k < NUM_CLASSES; k++) acc_d[k] = '0;
                    chunk_cnt_d = '0;
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                if (handshake) begin
                    query_d     = query_chunk;
                    add_pend_d  = 1'b1;
                    chunk_cnt_d = chunk_cnt_q + ADDR_W'(1);
                    if (chunk_cnt_q == ADDR_W'(NUM_CHUNKS - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                infer_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the accumulators are ordinary flops, not SRAM, so they are reset along with the FSM.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            chunk_cnt_q <= '0;
            query_q     <= '0;
            add_pend_q  <= 1'b0;
            infer_q     <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) acc_q[k] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            chunk_cnt_q <= chunk_cnt_d;
            query_q     <= query_d;
            add_pend_q  <= add_pend_d;
            infer_q     <= infer_d;
            for (int k = 0; k < NUM_CLASSES; k++) acc_q[k] <= acc_d[k];
        end
    end

    assign query_ready       = (state_q == ACCUM);
    assign am_rd_en          = handshake;
    assign am_rd_addr        = chunk_cnt_q;
    assign busy              = (state_q != IDLE);
    assign inferring_class   = infer_q;
    assign similarity_values = acc_q;

endmodule

// File: tb/tb_am_similarity_accumulator.sv
// Randomized self-checking bench: an AM SRAM model plus a popcount reference of each query.
module tb_am_similarity_accumulator;
    import am_pkg::*;

    logic                                clk = 1'b0;
    logic                                nrst;
    logic                                start;
    logic                                query_valid;
    logic                                query_ready;
    logic [CHUNK_W-1:0]                  query_chunk;
    logic                                am_rd_en;
    logic [ADDR_W-1:0]                   am_rd_addr;
    logic [NUM_CLASSES-1:0][CHUNK_W-1:0] am_rd_data = '0;
    sim_t                                similarity_values [0:NUM_CLASSES-1];
    logic                                inferring_class;
    logic                                busy;

    logic [CHUNK_W-1:0] mem [NUM_CLASSES][NUM_CHUNKS];
    logic [CHUNK_W-1:0] qry [NUM_CHUNKS];

    int n_checks = 0;
    int n_errors = 0;
    int rd_en_cnt = 0;
    int infer_cnt = 0;

    am_similarity_accumulator dut (
        .clk               (clk),
        .nrst              (nrst),
        .start             (start),
        .query_valid       (query_valid),
        .query_ready       (query_ready),
        .query_chunk       (query_chunk),
        .am_rd_en          (am_rd_en),
        .am_rd_addr        (am_rd_addr),
        .am_rd_data        (am_rd_data),
        .similarity_values (similarity_values),
        .inferring_class   (inferring_class),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // AM SRAM: one-cycle read latency, every class chunk at the same address.
    always @(posedge clk) begin
        if (am_rd_en) begin
            for (int k = 0; k < NUM_CLASSES; k++) am_rd_data[k] <= mem[k][am_rd_addr];
        end
    end

    always @(negedge clk) begin
        if (am_rd_en) rd_en_cnt++;
        if (inferring_class) infer_cnt++;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_sim(input int k);
        int s = 0;
        for (int c = 0; c < NUM_CHUNKS; c++) s += $countones(qry[c] & mem[k][c]);
        return s;
    endfunction

    function automatic logic [CHUNK_W-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic randomize_data();
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            qry[c] = rand_word() & rand_word();
            for (int k = 0; k < NUM_CLASSES; k++) mem[k][c] = rand_word();
        end
    endtask

    task automatic check_results(input string name);
        for (int k = 0; k < NUM_CLASSES; k++)
            check($sformatf("%s_sim[%0d]", name, k), similarity_values[k], ref_sim(k));
    endtask

    // Entered and left at 1 time unit after a rising edge with the DUT in IDLE.
    task automatic run_query(input string name, input int gap_pct, input bit spurious);
        int c = 0;
        int guard = 0;
        int rd0;
        int inf0;
        check({name, "_idle_busy"}, busy, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_busy"}, busy, 1);
        for (int k = 0; k < NUM_CLASSES; k++)
            check($sformatf("%s_clear[%0d]", name, k), similarity_values[k], 0);
        rd0  = rd_en_cnt;
        inf0 = infer_cnt;
        while (c < NUM_CHUNKS && guard < 4000) begin
            query_valid = ($urandom_range(99) >= gap_pct);
            query_chunk = qry[c];
            if (spurious) start = ($urandom_range(3) == 0);
            #1;
            if (query_valid && query_ready) begin
                check($sformatf("%s_rd_en[%0d]", name, c), am_rd_en, 1);
                check($sformatf("%s_rd_addr[%0d]", name, c), am_rd_addr, c);
                c++;
            end
            @(posedge clk); #1;
            guard++;
        end
        query_valid = 1'b0;
        start       = 1'b0;
        check({name, "_chunks_accepted"}, c, NUM_CHUNKS);
        check({name, "_drain_infer"}, inferring_class, 0);
        check({name, "_drain_ready"}, query_ready, 0);
        @(posedge clk); #1;
        check({name, "_done_infer"}, inferring_class, 1);
        check_results(name);
        if (spurious) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_idle_infer"}, inferring_class, 0);
        check({name, "_idle_busy_after"}, busy, 0);
        check({name, "_rd_count"}, rd_en_cnt - rd0, NUM_CHUNKS);
        check({name, "_infer_count"}, infer_cnt - inf0, 1);
        if (spurious) begin
            @(posedge clk); #1;
            check({name, "_no_restart"}, busy, 0);
            check({name, "_held_sim0"}, similarity_values[0], ref_sim(0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst        = 1'b0;
        start       = 1'b0;
        query_valid = 1'b0;
        query_chunk = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", query_ready, 0);
        check("rst_infer", inferring_class, 0);
        check("rst_rd_en", am_rd_en, 0);
        for (int k = 0; k < NUM_CLASSES; k++)
            check($sformatf("rst_sim[%0d]", k), similarity_values[k], 0);
        nrst = 1'b1;
        @(posedge clk); #1;

        // Single match: all-ones query against an all-ones class 3.
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            qry[c] = '1;
            for (int k = 0; k < NUM_CLASSES; k++) mem[k][c] = (k == 3) ? '1 : '0;
        end
        run_query("match", 0, 1'b0);
        check("match_sim3_full", similarity_values[3], HV_DIM);

        // Sparse overlap: class k shares bit 0 with the query in chunks below k.
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            qry[c] = CHUNK_W'(1);
            for (int k = 0; k < NUM_CLASSES; k++) mem[k][c] = (c < k) ? CHUNK_W'(1) : '0;
        end
        run_query("sparse", 0, 1'b0);
        for (int k = 0; k < NUM_CLASSES; k++)
            check($sformatf("sparse_direct[%0d]", k), similarity_values[k], k);

        // Same random data with and without bubbles.
        randomize_data();
        run_query("rand_nogap", 0, 1'b0);
        run_query("rand_gap", 50, 1'b0);

        // Start pulses during ACCUM and DONE must be ignored.
        randomize_data();
        run_query("spurious", 30, 1'b1);

        // Reset in the middle of accumulation discards partial sums.
        randomize_data();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            query_valid = 1'b1;
            query_chunk = qry[c];
            @(posedge clk); #1;
        end
        query_valid = 1'b0;
        nrst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", query_ready, 0);
        check("midrst_infer", inferring_class, 0);
        for (int k = 0; k < NUM_CLASSES; k++)
            check($sformatf("midrst_sim[%0d]", k), similarity_values[k], 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        run_query("post_rst", 0, 1'b0);

        // Back-to-back queries, start issued in the cycle right after DONE.
        for (int i = 0; i < 3; i++) begin
            randomize_data();
            run_query($sformatf("b2b%0d", i), 25, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
